// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer owning the HI/LO registers.
// It runs MULT/MULTU/DIV/DIVU over nbits iteration cycles next to the EX-stage
// ALU, serves MTHI/MTLO writes while idle, and asks the hazard unit to freeze
// the pipeline while an operation is in flight.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start, op           mult/div instruction valid; 00 MULTU 01 MULT 10 DIVU 11 DIV
//   op_a, op_b          forwarded rs / rt values
//   rd_hilo             MFHI/MFLO present in EX
//   wr_hi, wr_lo        MTHI / MTLO with wr_data
//   flush               kill the in-flight operation
//   hi_out, lo_out      architectural HI / LO
//   busy, done          operation in flight / one-cycle result-written pulse
//   stall_req           freeze IF/ID/EX
module muldiv_ctrl #(
  parameter int unsigned nbits = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [nbits-1:0] op_a,
  input  logic [nbits-1:0] op_b,
  input  logic             rd_hilo,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [nbits-1:0] wr_data,
  input  logic             flush,
  output logic [nbits-1:0] hi_out,
  output logic [nbits-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  localparam int unsigned CW = (nbits > 1) ? $clog2(nbits) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*nbits-1:0]   acc_q, acc_d;
  logic [nbits-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;     // negate product / quotient
  logic                 rneg_q, rneg_d;   // negate remainder
  logic [nbits-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 a_neg, b_neg;
  logic [nbits-1:0]     a_abs, b_abs;
  logic [nbits:0]       mul_sum, div_r, div_diff;
  logic [2*nbits-1:0]   mul_step, div_step, prod;
  logic [nbits-1:0]     quo, rem;

  assign a_neg = op[0] & op_a[nbits-1];
  assign b_neg = op[0] & op_b[nbits-1];
  assign a_abs = a_neg ? -op_a : op_a;
  assign b_abs = b_neg ? -op_b : op_b;

  // Shift-add: multiplier sits in the low half and is consumed LSB first,
  // the partial product grows in the high half (with carry) as it shifts right.
  assign mul_sum  = {1'b0, acc_q[2*nbits-1:nbits]} + {1'b0, opnd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[nbits-1:1]}
                             : {1'b0, acc_q[2*nbits-1:1]};

  // Restoring divide: remainder in the high half, dividend shifts in from the
  // low half while quotient bits fill in from the right. The borrow bit of
  // the 33-bit trial subtraction decides restore vs. keep.
  assign div_r    = acc_q[2*nbits-1:nbits-1];
  assign div_diff = div_r - {1'b0, opnd_q};
  assign div_step = div_diff[nbits] ? {div_r[nbits-1:0], acc_q[nbits-2:0], 1'b0}
                                    : {div_diff[nbits-1:0], acc_q[nbits-2:0], 1'b1};

  assign prod = neg_q  ? -acc_q : acc_q;
  assign quo  = neg_q  ? -acc_q[nbits-1:0] : acc_q[nbits-1:0];
  assign rem  = rneg_q ? -acc_q[2*nbits-1:nbits] : acc_q[2*nbits-1:nbits];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          count_d = '0;
          div_d   = op[1];
          neg_d   = a_neg ^ b_neg;
          rneg_d  = op[1] & a_neg;
          if (op[1]) begin
            if (op_b == '0) begin
              // Divide by zero: preload the final HI/LO image with no
              // sign fix-up so FINISH writes it through unchanged.
              acc_d   = {op_a, {nbits{1'b1}}};
              neg_d   = 1'b0;
              rneg_d  = 1'b0;
              state_d = FINISH;
            end else begin
              acc_d   = {{nbits{1'b0}}, a_abs};
              opnd_d  = b_abs;
              state_d = RUN;
            end
          end else begin
            acc_d   = {{nbits{1'b0}}, b_abs};
            opnd_d  = a_abs;
            state_d = RUN;
          end
        end else begin
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = div_q ? div_step : mul_step;
          count_d = count_q + 1'b1;
          if (count_q == CW'(nbits - 1)) state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*nbits-1:nbits];
            lo_d = prod[nbits-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign stall_req = busy & (start | rd_hilo | wr_hi | wr_lo);

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer with HI/LO architectural registers for the MIPS pipeline.
- Sits beside the EX-stage ALU and takes the same forwarded operands (post-forwarding-mux rs/rt values).
- Runs MULT/MULTU/DIV/DIVU over 32 iteration cycles.
- Serves MFHI/MFLO/MTHI/MTLO and raises a stall request toward the hazard unit while an operation is in flight.

Parameters:
- nbits, 32, operand/HI/LO width; iteration count = nbits.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  EX-stage mult/div instruction valid
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- op_a  in  32  forwarded rs value (multiplicand/dividend)
- op_b  in  32  forwarded rt value (multiplier/divisor)
- rd_hilo  in  1  EX-stage MFHI/MFLO present
- wr_hi  in  1  MTHI
- wr_lo  in  1  MTLO
- wr_data  in  32  MTHI/MTLO data
- flush  in  1  kill in-flight operation (branch/exception)
- hi_out  out  32  HI register
- lo_out  out  32  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO updated by mult/div
- stall_req  out  1  freeze IF/ID/EX

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, hi_out=lo_out=0, count=0, busy=0, done=0. Reset overrides any operation in flight.
- FSM states:
  - IDLE: start=1 and flush=0 → capture |op_a| and |op_b| (signed ops), result signs, and op; count=0; → RUN. DIV/DIVU with op_b=0 → FINISH directly.
  - RUN: one iteration per edge, count++.
    - Multiply: shift-add on 64-bit accumulator.
    - Divide: restoring shift-subtract.
    - At the edge where count==nbits-1 → FINISH.
  - FINISH: one edge. Apply sign correction, write HI/LO, done=1 next cycle → IDLE.
- Latency: start sampled at edge T; iterations at edges T+1..T+32; HI/LO written at edge T+33; done high in cycle after T+33. busy = (state!=IDLE).
- Arithmetic:
  - Multiply: {HI,LO} = 64-bit product. Signed result negated when exactly one operand is negative.
  - Divide: LO = quotient, HI = remainder. Quotient negative iff operand signs differ; remainder takes dividend sign (truncating division).
  - 0x80000000 / -1 (DIV) → LO=0x80000000, HI=0.
  - Divide by zero → LO=0xFFFFFFFF, HI=op_a, latency 2 edges (capture, FINISH).
- HI/LO access:
  - In IDLE, wr_hi/wr_lo write wr_data at next edge.
  - start has priority: a write in the same cycle as start is dropped.
- stall_req (combinational) = busy & (start | rd_hilo | wr_hi | wr_lo).
  - start seen while busy is ignored; the pipeline re-presents it after busy drops.
  - In the FINISH cycle a rd_hilo still stalls; the read is served from updated registers the following cycle.
- flush: in RUN or FINISH, next edge → IDLE. HI/LO unchanged, done stays 0. Flush with start in IDLE → start ignored.
- No back-to-back chaining: a new start is accepted only in IDLE.

Test Plan:
- MULT op_a=0xFFFFFFFD (-3), op_b=5 → after edge T+33: HI=0xFFFFFFFF, LO=0xFFFFFFF1, done one cycle, busy 0 thereafter.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 → LO=0x0000000E, HI=0x00000002; DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- DIV 1234/0 → done after 2 edges, LO=0xFFFFFFFF, HI=0x000004D2.
- Hazards:
  - rd_hilo=1 at iteration 5 → stall_req=1 until FINISH completes; lo_out reads the new result the cycle after done.
  - A second start during busy → stall_req=1, no restart.
- Abort and reset:
  - Preload HI=0xAAAA0000, LO=0x5555 via MTHI/MTLO; start MULT, flush at iteration 10 → IDLE, HI/LO unchanged, done never asserts.
  - rst_n=0 mid-RUN → all outputs 0 next edge.
